// File: rtl/alu_sequencer.sv
// ============================================================================
// Module  : alu_sequencer
// Purpose : Three-state instruction sequencer driving an external 4-bit ALU
//           with a 4x4-bit register file and a locally handled LOADI.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module alu_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    input  logic [11:0] instr,
    output logic        instr_ready,
    output logic [3:0]  alu_A,
    output logic [3:0]  alu_B,
    output logic [3:0]  alu_opcode,
    input  logic [3:0]  alu_result,
    input  logic        alu_carry,
    input  logic        alu_zero,
    output logic        done,
    output logic [3:0]  wb_data,
    output logic        carry_q,
    output logic        zero_q,
    output logic [15:0] regs_flat
);

    localparam logic [3:0] c_OP_LOADI = 4'b1110;
    localparam logic [3:0] c_OP_PASSA = 4'b1111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WB    = 2'd2
    } state_t;

    state_t      r_state;
    logic [11:0] r_instr;
    logic [3:0]  r_regs [4];

    assign regs_flat = {r_regs[3], r_regs[2], r_regs[1], r_regs[0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_instr     <= '0;
            for (int i = 0; i < 4; i++) begin
                r_regs[i] <= '0;
            end
            instr_ready <= 1'b1;
            alu_A       <= '0;
            alu_B       <= '0;
            alu_opcode  <= c_OP_PASSA;
            done        <= 1'b0;
            wb_data     <= '0;
            carry_q     <= 1'b0;
            zero_q      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    // Operands are captured at accept time; no write can be
                    // in flight here, so these are the pre-write values.
                    if (instr_valid && instr_ready) begin
                        r_instr     <= instr;
                        alu_A       <= r_regs[instr[5:4]];
                        alu_B       <= r_regs[instr[3:2]];
                        alu_opcode  <= instr[11:8];
                        instr_ready <= 1'b0;
                        r_state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    alu_A      <= '0;
                    alu_B      <= '0;
                    alu_opcode <= c_OP_PASSA;
                    done       <= 1'b1;
                    r_state    <= WB;
                    if (r_instr[11:8] == c_OP_LOADI) begin
                        r_regs[r_instr[7:6]] <= r_instr[3:0];
                        wb_data              <= r_instr[3:0];
                        carry_q              <= 1'b0;
                        zero_q               <= (r_instr[3:0] == 4'd0);
                    end else begin
                        r_regs[r_instr[7:6]] <= alu_result;
                        wb_data              <= alu_result;
                        carry_q              <= alu_carry;
                        zero_q               <= alu_zero;
                    end
                end
                WB: begin
                    done        <= 1'b0;
                    instr_ready <= 1'b1;
                    r_state     <= IDLE;
                end
                default: begin
                    done        <= 1'b0;
                    instr_ready <= 1'b1;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_alu_sequencer.sv
// ============================================================================
// Module  : tb_alu_sequencer
// Purpose : Directed self-checking bench for alu_sequencer with a reference
//           ALU and an instruction-level model compared every cycle.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_alu_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        instr_valid = 1'b0;
    logic [11:0] instr = '0;
    logic        instr_ready;
    logic [3:0]  alu_A, alu_B, alu_opcode, alu_result;
    logic        alu_carry, alu_zero;
    logic        done;
    logic [3:0]  wb_data;
    logic        carry_q, zero_q;
    logic [15:0] regs_flat;

    int n_vec  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int dcnt   = 0;
    bit chk_en = 0;
    int acc_q[$];

    always #5 clk = ~clk;

    // External ALU: {carry, result}
    function automatic logic [4:0] alu_f(input logic [3:0] op, input logic [3:0] a,
                                         input logic [3:0] b);
        logic [4:0] t;
        case (op)
            4'b0000: t = {1'b0, a} + {1'b0, b};
            4'b0001: t = {(a < b), 4'(a - b)};
            4'b0010: t = {1'b0, a & b};
            4'b0011: t = {1'b0, a | b};
            4'b0100: t = {1'b0, ~a};
            4'b1111: t = {1'b0, a};
            default: t = 5'd0;
        endcase
        return t;
    endfunction

    assign {alu_carry, alu_result} = alu_f(alu_opcode, alu_A, alu_B);
    assign alu_zero = (alu_result == 4'd0);

    alu_sequencer dut (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr),
        .instr_ready(instr_ready), .alu_A(alu_A), .alu_B(alu_B),
        .alu_opcode(alu_opcode), .alu_result(alu_result), .alu_carry(alu_carry),
        .alu_zero(alu_zero), .done(done), .wb_data(wb_data), .carry_q(carry_q),
        .zero_q(zero_q), .regs_flat(regs_flat)
    );

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Instruction-level model: age -1 = free, 0 = accepted last edge, 1 = retired last edge
    int          m_age = -1;
    logic [11:0] m_ins = '0;
    logic [3:0]  m_r [4] = '{default: 4'd0};
    logic [3:0]  m_wb = '0;
    logic        m_c = 1'b0, m_z = 1'b0;

    initial forever begin
        logic [4:0] res;
        @(posedge clk);
        cyc++;
        if (!rst && instr_valid && instr_ready) acc_q.push_back(cyc);
        if (rst) begin
            m_age = -1;
            for (int i = 0; i < 4; i++) m_r[i] = 4'd0;
            m_wb = 4'd0; m_c = 1'b0; m_z = 1'b0;
        end else if (m_age < 0) begin
            if (instr_valid) begin
                m_ins = instr;
                m_age = 0;
            end
        end else if (m_age == 0) begin
            if (m_ins[11:8] == 4'b1110) res = {1'b0, m_ins[3:0]};
            else res = alu_f(m_ins[11:8], m_r[m_ins[5:4]], m_r[m_ins[3:2]]);
            m_r[m_ins[7:6]] = res[3:0];
            m_wb = res[3:0];
            m_c  = res[4];
            m_z  = (res[3:0] == 4'd0);
            m_age = 1;
        end else begin
            m_age = -1;
        end
    end

    initial forever begin
        @(negedge clk);
        if (done) dcnt++;
        if (chk_en) begin
            check("ready", {15'd0, instr_ready}, {15'd0, m_age < 0});
            check("done", {15'd0, done}, {15'd0, m_age == 1});
            check("regs_flat", regs_flat, {m_r[3], m_r[2], m_r[1], m_r[0]});
            check("wb_data", {12'd0, wb_data}, {12'd0, m_wb});
            check("carry_q", {15'd0, carry_q}, {15'd0, m_c});
            check("zero_q", {15'd0, zero_q}, {15'd0, m_z});
            check("alu_A", {12'd0, alu_A}, (m_age == 0) ? {12'd0, m_r[m_ins[5:4]]} : 16'd0);
            check("alu_B", {12'd0, alu_B}, (m_age == 0) ? {12'd0, m_r[m_ins[3:2]]} : 16'd0);
            check("alu_opcode", {12'd0, alu_opcode}, (m_age == 0) ? {12'd0, m_ins[11:8]} : 16'hF);
        end
    end

    task automatic send(input logic [11:0] ins);
        int b = 0;
        @(negedge clk);
        instr = ins;
        instr_valid = 1'b1;
        while (!instr_ready && b < 10) begin
            @(negedge clk);
            b++;
        end
        if (b >= 10) check("accept_timeout", 16'd0, 16'd1);
        @(negedge clk);
        instr_valid = 1'b0;
    endtask

    task automatic exec(input logic [11:0] ins);
        int k = 0;
        send(ins);
        while (!done && k < 6) begin
            @(negedge clk);
            k++;
        end
        check("done_latency", 16'(k), 16'd1);
        @(negedge clk);
    endtask

    logic [11:0] prog [4] = '{12'hE03, 12'hE44, 12'h084, 12'h3E0};

    initial begin
        int b, d0;
        repeat (2) @(negedge clk);
        chk_en = 1;
        check("rst_ready", {15'd0, instr_ready}, 16'd1);
        check("rst_regs", regs_flat, 16'h0000);
        check("rst_opcode", {12'd0, alu_opcode}, 16'hF);
        rst = 1'b0;

        exec(12'hE49);                       // LOADI r1,#9
        exec(12'hE87);                       // LOADI r2,#7
        check("loadi_regs", regs_flat, 16'h0790);
        exec(12'h0D8);                       // ADD r3,r1,r2
        check("add_wb", {12'd0, wb_data}, 16'h0);
        check("add_carry", {15'd0, carry_q}, 16'd1);
        check("add_zero", {15'd0, zero_q}, 16'd1);
        exec(12'h124);                       // SUB r0,r2,r1
        check("sub_wb", {12'd0, wb_data}, 16'hE);
        check("sub_carry", {15'd0, carry_q}, 16'd1);
        check("sub_zero", {15'd0, zero_q}, 16'd0);
        exec(12'h453);                       // NOT r1,r1 with reserved bits set
        check("not_r1", {12'd0, regs_flat[7:4]}, 16'h6);
        exec(12'hE85);                       // LOADI r2,#5
        exec(12'h680);                       // undefined op to r2
        check("undef_r2", {12'd0, regs_flat[11:8]}, 16'h0);
        check("undef_carry", {15'd0, carry_q}, 16'd0);
        check("undef_zero", {15'd0, zero_q}, 16'd1);
        repeat (3) @(negedge clk);
        check("hold_wb", {12'd0, wb_data}, 16'h0);

        // Back-to-back with instr_valid held high
        d0 = dcnt;
        acc_q.delete();
        @(negedge clk);
        instr_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            instr = prog[i];
            b = 0;
            while (!instr_ready && b < 10) begin
                @(negedge clk);
                b++;
            end
            if (b >= 10) check("stream_timeout", 16'd0, 16'd1);
            @(negedge clk);
        end
        instr_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("stream_dones", 16'(dcnt - d0), 16'd4);
        check("stream_accepts", 16'(acc_q.size()), 16'd4);
        for (int i = 0; i + 1 < acc_q.size(); i++)
            check("stream_gap", 16'(acc_q[i+1] - acc_q[i]), 16'd3);
        check("stream_regs", regs_flat, 16'h7743);

        // Reset during ISSUE aborts the ADD
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        d0 = dcnt;
        send(12'h0D8);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_ready", {15'd0, instr_ready}, 16'd1);
        check("abort_done", {15'd0, done}, 16'd0);
        repeat (2) @(negedge clk);
        check("abort_dones", 16'(dcnt - d0), 16'd0);
        check("abort_regs", regs_flat, 16'h0000);

        // Instruction presented together with reset is dropped
        rst = 1'b1; instr_valid = 1'b1; instr = 12'hE49;
        @(negedge clk);
        rst = 1'b0; instr_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("rst_drop_regs", regs_flat, 16'h0000);
        check("rst_drop_dones", 16'(dcnt - d0), 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule

`default_nettype wire
